// File: rtl/comp_pkg.sv
// Shared definitions for the magnitude comparators.
// Holds the scan FSM state encoding and the three-flag result encoding
// {LG, EQ, RG}. The ripple comparators use the same result constants.
package comp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    FIN  = 2'd2
  } state_e;

  localparam logic [2:0] RES_LG   = 3'b100;  // X > Y
  localparam logic [2:0] RES_EQ   = 3'b010;  // X == Y
  localparam logic [2:0] RES_RG   = 3'b001;  // X < Y
  localparam logic [2:0] RES_NONE = 3'b000;  // no compare completed yet

endpackage : comp_pkg

// File: rtl/comp_bit_msb.sv
// One-bit MSB-first compare cell (combinational).
// Ports:
//   x_i, y_i     : operand bits at the current scan position
//   resolved_i   : a difference was already seen at a more significant bit
//   res_i        : result recorded so far
//   res_o        : result after this bit
//   resolved_o   : resolved flag after this bit
// The first differing bit from the top decides; later bits never override it.
module comp_bit_msb
  import comp_pkg::*;
(
  input  logic       x_i,
  input  logic       y_i,
  input  logic       resolved_i,
  input  logic [2:0] res_i,
  output logic [2:0] res_o,
  output logic       resolved_o
);

  always_comb begin
    res_o      = res_i;
    resolved_o = resolved_i;
    if (!resolved_i && (x_i != y_i)) begin
      res_o      = x_i ? RES_LG : RES_RG;
      resolved_o = 1'b1;
    end
  end

endmodule : comp_bit_msb

// File: rtl/serial_comp_msb.sv
// Serial MSB-first magnitude comparator: one bit per clock through a single
// compare cell, result reported as {lg, eq, rg}.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start_i             : compare request, accepted in IDLE or FIN
//   x_i, y_i            : operands, captured on an accepted request
//   busy_o              : high while scanning
//   done_o              : one-cycle pulse, result valid from this cycle
//   lg_out_o/eq_out_o/rg_out_o : X>Y / X==Y / X<Y, held until next result
// Build option: define SERIAL_COMP_EARLY_EXIT_EN to leave the scan on the first
// differing bit; otherwise every compare scans all WIDTH bits (constant time).
module serial_comp_msb
  import comp_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             lg_out_o,
  output logic             eq_out_o,
  output logic             rg_out_o
);

  localparam int unsigned IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

`ifdef SERIAL_COMP_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [2:0]       res_q, res_d;
  logic             resolved_q, resolved_d;
  logic [2:0]       flags_q, flags_d;
  logic             busy_q, done_q;

  logic [2:0]       cell_res;
  logic             cell_resolved;

  // Operands shift left each scan cycle, so the bit under test is always the MSB.
  comp_bit_msb u_bit (
    .x_i        (x_q[WIDTH-1]),
    .y_i        (y_q[WIDTH-1]),
    .resolved_i (resolved_q),
    .res_i      (res_q),
    .res_o      (cell_res),
    .resolved_o (cell_resolved)
  );

  // Next-state, datapath and result logic.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    idx_d      = idx_q;
    res_d      = res_q;
    resolved_d = resolved_q;
    flags_d    = flags_q;

    unique case (state_q)
      IDLE, FIN: begin
        state_d = IDLE;
        if (start_i) begin
          state_d    = SCAN;
          x_d        = x_i;
          y_d        = y_i;
          idx_d      = IDX_TOP;
          res_d      = RES_NONE;
          resolved_d = 1'b0;
        end
      end
      SCAN: begin
        res_d      = cell_res;
        resolved_d = cell_resolved;
        x_d        = {x_q[WIDTH-2:0], 1'b0};
        y_d        = {y_q[WIDTH-2:0], 1'b0};
        if ((idx_q == '0) || (EARLY_EXIT && cell_resolved)) begin
          state_d = FIN;
          flags_d = cell_resolved ? cell_res : RES_EQ;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      idx_q      <= '0;
      res_q      <= RES_NONE;
      resolved_q <= 1'b0;
      flags_q    <= RES_NONE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      idx_q      <= idx_d;
      res_q      <= res_d;
      resolved_q <= resolved_d;
      flags_q    <= flags_d;
      busy_q     <= (state_d == SCAN);
      done_q     <= (state_d == FIN);
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign lg_out_o = flags_q[2];
  assign eq_out_o = flags_q[1];
  assign rg_out_o = flags_q[0];

endmodule : serial_comp_msb

// File: tb/tb_serial_comp_msb.sv
// Scoreboard bench for serial_comp_msb (WIDTH=8). Stimulus pushes the expected
// flags and DONE edge; a monitor pops and compares on every DONE pulse.
module tb_serial_comp_msb;

  localparam int unsigned W = 8;
  localparam int LIMIT = 40;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] x, y;
  logic         busy, done, lg, eq, rg;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [2:0] flags;
    int         done_edge;
    string      name;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   flags;
    int           k;  // highest differing bit, -1 when equal
  } vec_t;

  serial_comp_msb #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start),
    .x_i      (x),
    .y_i      (y),
    .busy_o   (busy),
    .done_o   (done),
    .lg_out_o (lg),
    .eq_out_o (eq),
    .rg_out_o (rg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // DONE edge offset from the accepting edge, given the first differing bit.
  function automatic int lat(input int k);
`ifdef SERIAL_COMP_EARLY_EXIT_EN
    if (k >= 0) return int'(W) - k;
`endif
    return int'(W);
  endfunction

  // Monitor: every DONE must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'(cyc), 64'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_flags"}, 64'({lg, eq, rg}), 64'(e.flags));
        check({e.name, "_done_cycle"}, 64'(cyc), 64'(e.done_edge));
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2:0] f, input int k, input string name, input bit push);
    int t;
    @(posedge clk); #1;
    start = 1'b1; x = a; y = b;
    t = cyc + 1;
    if (push) sb.push_back('{f, t + lat(k), name});
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < LIMIT && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      check({name, "_timeout"}, 64'(sb.size()), 64'(0));
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  vec_t vecs[8] = '{
    '{8'hA5, 8'hA5, 3'b010, -1},
    '{8'h80, 8'h7F, 3'b100,  7},
    '{8'h12, 8'h13, 3'b001,  0},
    '{8'hFF, 8'h00, 3'b100,  7},
    '{8'h00, 8'h01, 3'b001,  0},
    '{8'h3C, 8'h34, 3'b100,  3},
    '{8'h7F, 8'hFF, 3'b001,  7},
    '{8'h00, 8'h00, 3'b010, -1}
  };

  initial begin
    int t;
    rst_n = 1'b0; start = 1'b0; x = '0; y = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_flags", 64'({lg, eq, rg}), 64'(0));

    // Directed table.
    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].flags, vecs[i].k, $sformatf("vec%0d", i), 1'b1);
      wait_idle($sformatf("vec%0d", i));
      repeat (2) @(posedge clk);
      #1;
      check($sformatf("vec%0d_hold", i), 64'({lg, eq, rg}), 64'(vecs[i].flags));
      check($sformatf("vec%0d_busy_low", i), 64'(busy), 64'(0));
    end

    // Operand changes and START pulse during SCAN are ignored.
    issue(8'hA5, 8'hA5, 3'b010, -1, "midscan", 1'b1);
    check("midscan_busy", 64'(busy), 64'(1));
    x = 8'h00; y = 8'hFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle("midscan");
    repeat (6) @(posedge clk);
    #1;
    check("midscan_no_restart", 64'(busy), 64'(0));

    // Back-to-back: START held through FIN with new operands.
    @(posedge clk); #1;
    start = 1'b1; x = 8'h12; y = 8'h13;
    t = cyc + 1;
    sb.push_back('{3'b001, t + 8, "b2b_first"});
    sb.push_back('{3'b001, t + 9 + lat(1), "b2b_second"});
    @(posedge clk); #1;
    x = 8'h01; y = 8'h02;
    while (cyc < t + 9) @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_no_gap", 64'(busy), 64'(1));
    wait_idle("b2b");

    // Reset mid-scan aborts immediately and loses the result.
    issue(8'hA5, 8'hA5, 3'b010, -1, "abort", 1'b0);
    @(posedge clk); @(negedge clk);
    check("abort_busy_before", 64'(busy), 64'(1));
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    check("abort_flags", 64'({lg, eq, rg}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("abort_flags_after", 64'({lg, eq, rg}), 64'(0));
    check("abort_idle", 64'(busy), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_serial_comp_msb
